// File: rtl/ram32_byte_ctrl.sv
// Byte-serial command sequencer for a 32x32 synchronous DFF RAM macro.
// Assembles byte-masked word writes and streams read words out byte-wise.
module ram32_byte_ctrl #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYTES  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [7:0]            rsp_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic                  ram_en,
  output logic [BYTES-1:0]      ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [8*BYTES-1:0]    ram_wdata,
  input  logic [8*BYTES-1:0]    ram_rdata
);

  localparam int unsigned DATA_W = 8 * BYTES;
  localparam int unsigned CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, W_MASK, W_DATA, COMMIT, R_ISSUE, R_CAPTURE, R_SEND
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic [ADDR_W-1:0]   ea, ea_n;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
  logic [BYTES-1:0]    mask, mask_n;
  logic [DATA_W-1:0]   word, word_n;

  logic                cmd_ready_n, busy_n, rsp_valid_n, ram_en_n;
  logic [7:0]          rsp_data_n;
  logic [BYTES-1:0]    ram_we_n;
  logic [ADDR_W-1:0]   ram_addr_n;
  logic [DATA_W-1:0]   ram_wdata_n;
  logic                cmd_take;

  // Reserved command bit carries no meaning.
  logic unused_rsvd;
  assign unused_rsvd = cmd_data[5];

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      ptr       <= '0;
      ea        <= '0;
      cnt       <= '0;
      mask      <= '0;
      word      <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      ea        <= ea_n;
      cnt       <= cnt_n;
      mask      <= mask_n;
      word      <= word_n;
      cmd_ready <= cmd_ready_n;
      busy      <= busy_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      ram_en    <= ram_en_n;
      ram_we    <= ram_we_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
    end
  end

  // Next-state and next-output logic; RAM-side and ready outputs look ahead on state_n.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    ea_n        = ea;
    cnt_n       = cnt;
    mask_n      = mask;
    word_n      = word;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    cmd_take    = cmd_valid & cmd_ready;
    cnt_inc     = cnt + 1'b1;

    case (state)
      IDLE: begin
        if (cmd_take) begin
          ea_n    = cmd_data[6] ? ptr : cmd_data[ADDR_W-1:0];
          state_n = cmd_data[7] ? W_MASK : R_ISSUE;
        end
      end
      W_MASK: begin
        if (cmd_take) begin
          mask_n  = cmd_data[BYTES-1:0];
          cnt_n   = '0;
          word_n  = '0;
          state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (cmd_take) begin
          word_n[{cnt, 3'b000} +: 8] = cmd_data;
          cnt_n = cnt_inc;
          if (cnt == LAST) state_n = COMMIT;
        end
      end
      COMMIT: begin
        ptr_n   = ea + 1'b1;
        state_n = IDLE;
      end
      R_ISSUE: begin
        state_n = R_CAPTURE;
      end
      R_CAPTURE: begin
        word_n  = ram_rdata;
        cnt_n   = '0;
        state_n = R_SEND;
      end
      R_SEND: begin
        // First cycle loads the output byte register; afterwards advance on each handshake.
        if (!rsp_valid) begin
          rsp_valid_n = 1'b1;
          rsp_data_n  = word[{cnt, 3'b000} +: 8];
        end else if (rsp_ready) begin
          if (cnt == LAST) begin
            rsp_valid_n = 1'b0;
            ptr_n       = ea + 1'b1;
            state_n     = IDLE;
          end else begin
            cnt_n      = cnt_inc;
            rsp_data_n = word[{cnt_inc, 3'b000} +: 8];
          end
        end
      end
      default: state_n = IDLE;
    endcase

    cmd_ready_n = (state_n == IDLE) || (state_n == W_MASK) || (state_n == W_DATA);
    busy_n      = (state_n != IDLE);
    ram_en_n    = (state_n == COMMIT) || (state_n == R_ISSUE);
    ram_we_n    = (state_n == COMMIT) ? mask_n : '0;
    ram_addr_n  = ram_en_n ? ea_n : ram_addr;
    ram_wdata_n = (state_n == COMMIT) ? word_n : ram_wdata;
  end

endmodule

// File: tb/tb_ram32_byte_ctrl.sv
// Directed self-checking bench for ram32_byte_ctrl with a behavioural 32x32 RAM.
module tb_ram32_byte_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        busy;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  ram32_byte_ctrl #(.ADDR_W(5), .BYTES(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  // Behavioural synchronous RAM: read-old-data, byte write enables, output clears when disabled.
  logic [31:0] mem [32];
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end else begin
      ram_rdata <= '0;
    end
  end

  // Free-running access log sampled mid-cycle.
  int unsigned en_cnt = 0;
  int unsigned we_cnt = 0;
  logic [4:0]  last_addr;
  logic [3:0]  last_we;
  logic [31:0] last_wdata;
  always @(negedge CLK) begin
    if (ram_en) begin
      en_cnt++;
      last_addr  = ram_addr;
      last_we    = ram_we;
      last_wdata = ram_wdata;
    end
    if (ram_we != 4'h0) we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("cmd_ready_timeout", 32'(n), 32'd0);
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("rsp_valid_timeout", 32'(n), 32'd0);
    b = rsp_data;
    @(posedge CLK);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic read_word(input logic [7:0] cmd, output logic [31:0] w);
    logic [7:0] b;
    send_byte(cmd);
    for (int i = 0; i < 4; i++) begin
      recv_byte(b);
      w[8*i +: 8] = b;
    end
  endtask

  task automatic write_word(input logic [7:0] cmd, input logic [7:0] m, input logic [31:0] d);
    logic [31:0] dv;
    dv = d;
    send_byte(cmd);
    send_byte(m);
    for (int i = 0; i < 4; i++) send_byte(dv[8*i +: 8]);
  endtask

  logic [31:0] w;
  int unsigned e0, we0;
  logic        stable;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[31] = 32'hCAFE_F00D;
    mem[0]  = 32'h0BAD_BEEF;
    RST_N = 1'b0; cmd_data = 8'h00; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state.
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Full write to address 5 with commit latency.
    e0 = en_cnt;
    write_word(8'h85, 8'h0F, 32'h1234_5678);
    chk("wr_commit_en", 32'(ram_en), 32'd1);
    chk("wr_commit_ready", 32'(cmd_ready), 32'd0);
    @(posedge CLK); #1;
    chk("wr_ready_back", 32'(cmd_ready), 32'd1);
    chk("wr_en_cycles", en_cnt - e0, 32'd1);
    chk("wr_addr", 32'(last_addr), 32'd5);
    chk("wr_we", 32'(last_we), 32'hF);
    chk("wr_wdata", last_wdata, 32'h1234_5678);

    // Read back with cycle-exact latency: accept at N, ram_en only N..N+1, rsp_valid from N+3.
    e0 = en_cnt;
    send_byte(8'h05);
    chk("rd_lat_en_n", 32'(ram_en), 32'd1);
    chk("rd_lat_addr", 32'(ram_addr), 32'd5);
    @(posedge CLK); #1;
    chk("rd_lat_en_n1", 32'(ram_en), 32'd0);
    @(posedge CLK); #1;
    chk("rd_lat_valid_n2", 32'(rsp_valid), 32'd0);
    @(posedge CLK); #1;
    chk("rd_lat_valid_n3", 32'(rsp_valid), 32'd1);
    chk("rd_lat_byte0", 32'(rsp_data), 32'h78);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      recv_byte(b);
      w[8*i +: 8] = b;
    end
    chk("rd_word", w, 32'h1234_5678);
    chk("rd_en_cycles", en_cnt - e0, 32'd1);
    chk("rd_idle_busy", 32'(busy), 32'd0);
    read_word(8'h40, w);
    chk("ptr_after_rd5", 32'(last_addr), 32'd6);

    // Partial write of byte 2 only.
    write_word(8'h85, 8'h04, 32'h00AB_0000);
    @(posedge CLK); #1;
    chk("pw_we", 32'(last_we), 32'h4);
    read_word(8'h05, w);
    chk("pw_readback", w, 32'h12AB_5678);

    // Pointer wrap from 31 to 0, then pointer-mode write lands at 1.
    read_word(8'h1F, w);
    chk("wrap_rd31", w, 32'hCAFE_F00D);
    read_word(8'h40, w);
    chk("wrap_addr0", 32'(last_addr), 32'd0);
    chk("wrap_rd0", w, 32'h0BAD_BEEF);
    write_word(8'hC0, 8'h0F, 32'h4433_2211);
    @(posedge CLK); #1;
    chk("wrap_wr_addr", 32'(last_addr), 32'd1);
    read_word(8'h01, w);
    chk("wrap_wr_data", w, 32'h4433_2211);

    // Back-pressure: output frozen, command port closed, pending byte not consumed.
    send_byte(8'h05);
    while (!rsp_valid) @(negedge CLK);
    e0 = en_cnt;
    cmd_data = 8'h9F; cmd_valid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (rsp_data !== 8'h78 || rsp_valid !== 1'b1 || cmd_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_no_access", en_cnt - e0, 32'd0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      recv_byte(b);
      w[8*i +: 8] = b;
    end
    chk("bp_word", w, 32'h12AB_5678);
    chk("bp_not_consumed", 32'(busy), 32'd0);

    // Reset in the middle of a write discards it.
    we0 = we_cnt;
    send_byte(8'h82);
    send_byte(8'h0F);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_ready", 32'(cmd_ready), 32'd1);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rstw_no_we", we_cnt - we0, 32'd0);
    read_word(8'h40, w);
    chk("rstw_ptr0", 32'(last_addr), 32'd0);
    read_word(8'h02, w);
    chk("rstw_old_data", w, 32'h0000_0000);

    // Asynchronous reset during response drops rsp_valid at once.
    send_byte(8'h05);
    while (!rsp_valid) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("rsts_valid", 32'(rsp_valid), 32'd0);
    chk("rsts_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ram32_byte_ctrl.md
Name: ram32_byte_ctrl

Overview:
Byte-serial command sequencer for the 32x32 DFF RAM macro. It suits an 8-bit pin budget such as a Tiny Tapeout tile. It accepts command/data bytes on a valid/ready port and assembles 32-bit writes with byte enables. For reads, it issues the synchronous RAM access, captures the word and streams it out byte-wise on a second valid/ready port. It also maintains an auto-incrementing address pointer.

Parameters:
ADDR_W, 5, RAM word-address width (depth 2**ADDR_W)
BYTES, 4, bytes per RAM word (data width 8*BYTES)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_N  in  1  reset, asynchronous, active-low
cmd_data  in  8  command/data byte
cmd_valid  in  1  cmd_data valid
cmd_ready  out  1  controller accepts byte (transfer = valid & ready at edge)
rsp_data  out  8  read-data byte
rsp_valid  out  1  rsp_data valid
rsp_ready  in  1  consumer accepts byte
busy  out  1  high whenever state != IDLE
ram_en  out  1  to RAM EN0
ram_we  out  BYTES  to RAM WE0
ram_addr  out  ADDR_W  to RAM A0
ram_wdata  out  8*BYTES  to RAM Di0
ram_rdata  in  8*BYTES  from RAM Do0

Behaviour:
- Reset (async assert) sets state=IDLE, ptr=0 and cnt=0. All outputs are 0, except cmd_ready=1 because it is IDLE-driven. A partial write in flight is discarded and no RAM write occurs. ram_we is forced to 0.
- RAM model: synchronous. With EN0=1 at edge E, Do0 holds the old word at A0 from E on. The write takes effect at E. With EN0=0, Do0 goes to 0 at the next edge.
- All RAM-side outputs are registered. ram_en=0 and ram_we=0 in every state except COMMIT and R_ISSUE.
- Command byte: bit7 W (1=write, 0=read); bit6 P (1=use ptr, ignore address field); bit5 reserved (ignored); bits4:0 A.
- Effective address EA = P ? ptr : A. After every completed operation, ptr <= EA+1, mod 2**ADDR_W (31 wraps to 0).
- IDLE: cmd_ready=1. A read command goes to R_ISSUE. A write command goes to W_MASK.
- W_MASK: cmd_ready=1. The accepted byte's low BYTES bits form the byte-enable mask; upper bits are ignored. Next state is W_DATA with cnt=0.
- W_DATA: cmd_ready=1. The accepted byte is loaded into wdata byte cnt, LSB first. After byte BYTES-1 is accepted, go to COMMIT.
- COMMIT (1 cycle): cmd_ready=0, ram_en=1, ram_we=mask, ram_addr=EA, ram_wdata=assembled word. Return to IDLE. Mask 0 performs an enabled access with no bytes written and produces no response.
- Write latency: last data byte accepted at edge N. RAM is written at edge N+1 and cmd_ready returns high after N+1.
- R_ISSUE (1 cycle): ram_en=1, ram_we=0, ram_addr=EA. Go to R_CAPTURE.
- R_CAPTURE (1 cycle): ram_en=0. At its ending edge, latch ram_rdata into the shift register, set cnt=0 and go to R_SEND.
- R_SEND: rsp_valid=1 and rsp_data = word byte cnt. On rsp_valid & rsp_ready, cnt++. After byte BYTES-1 is taken, clear rsp_valid and go to IDLE.
- Read latency: command accepted at edge N. rsp_valid is high from edge N+3 with byte 0.
- rsp_data and rsp_valid stay stable while rsp_ready=0. Back-pressure may last indefinitely.
- cmd_ready=0 in R_ISSUE, R_CAPTURE, R_SEND and COMMIT. cmd_valid may be held; no byte is consumed.
- cmd_valid=0 mid-write stalls W_MASK/W_DATA indefinitely with no timeout.
- Reset asserted mid-R_SEND drops rsp_valid immediately (asynchronous).

Test Plan:
- Write cmd 0x85, mask 0x0F, data 0x78,0x56,0x34,0x12 -> one cycle with ram_en=1, ram_we=4'hF, ram_addr=5, ram_wdata=0x12345678. Then read cmd 0x05 -> rsp bytes 0x78,0x56,0x34,0x12; ptr=6.
- Partial write to addr 5, mask 0x04, data 0x00,0x00,0xAB,0x00 -> ram_we=4'b0100. Read 0x05 returns 0x12AB5678.
- Pointer wrap: read 0x1F, then read 0x40 -> second ram_addr=0, ptr=1. Write 0xC0 -> lands at addr 1.
- Back-pressure: hold rsp_ready=0 for 10 cycles during R_SEND -> rsp_data frozen at byte 0. cmd_ready=0 throughout, and a pending cmd_valid is not consumed.
- Reset mid-write: assert RST_N=0 after 2 data bytes -> ram_we never nonzero, busy=0 and ptr=0. A subsequent read of that address returns its previous contents.
- Latency check: read accepted at edge N -> ram_en high only in cycle N..N+1, rsp_valid first high after edge N+3.
